// File: rtl/r_exec_ctrl.sv
// Multi-cycle R-format execution sequencer: decode -> register read -> ALU execute -> write-back.
// Optional performance counters are enabled with `define R_EXEC_PERF_CNT_EN.
module r_exec_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              zero_flag,
  output logic              done,
  output logic              illegal
`ifdef R_EXEC_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [15:0]       illegal_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_ILL    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       instr_q;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [DATA_W-1:0] rf_wd_q;
  logic              zero_q;

  logic [5:0]        op_f, funct_f;
  logic [4:0]        rs_f, rt_f, rd_f;
  logic              legal;
  logic              accept;
  logic              unused_shamt;

  assign op_f    = instr_q[31:26];
  assign rs_f    = instr_q[25:21];
  assign rt_f    = instr_q[20:16];
  assign rd_f    = instr_q[15:11];
  assign funct_f = instr_q[5:0];
  assign unused_shamt = ^instr_q[10:6];

  always_comb begin
    legal    = 1'b0;
    alu_op_d = alu_op_q;
    if (op_f == 6'h00) begin
      case (funct_f)
        6'h20: begin legal = 1'b1; alu_op_d = 3'b000; end
        6'h22: begin legal = 1'b1; alu_op_d = 3'b001; end
        6'h24: begin legal = 1'b1; alu_op_d = 3'b010; end
        6'h25: begin legal = 1'b1; alu_op_d = 3'b011; end
        6'h2A: begin legal = 1'b1; alu_op_d = 3'b100; end
        default: legal = 1'b0;
      endcase
    end
  end

  assign accept = instr_valid && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_ILL;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        rf_we   = (rd_f != 5'd0);
        done    = 1'b1;
        state_d = S_IDLE;
      end
      // Rejection pulse gets its own cycle so illegal and instr_ready never overlap.
      S_ILL: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      rf_wd_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
      if (state_q == S_DECODE && legal) begin
        alu_op_q <= alu_op_d;
        alu_a_q  <= rf_rd1;
        alu_b_q  <= rf_rd2;
      end
      if (state_q == S_EXEC) begin
        rf_wd_q <= alu_result;
        zero_q  <= alu_zero;
      end
    end
  end

  assign rf_ra1    = REG_AW'(rs_f);
  assign rf_ra2    = REG_AW'(rt_f);
  assign rf_wa     = REG_AW'(rd_f);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rf_wd     = rf_wd_q;
  assign zero_flag = zero_q;

`ifdef R_EXEC_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [15:0] illegal_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (done)    retired_q     <= retired_q + 32'd1;
      if (illegal) illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign illegal_cnt = illegal_cnt_q;
`else
  // Counters not built.
`endif

endmodule
